uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//   Buffered, runtime-configurable UART transmitter for the peripheral bus.
//   Words enter through a FIFO on a valid/ready handshake and are sent LSB-first as
//   start / data / [parity] / stop frames. Frames go back-to-back while the FIFO is non-empty.
//   Replaces the unbuffered single-word transmitter in new peripheral instances.
// PARAMETERS
//   CLK_FREQ    100000000  input clock frequency, Hz
//   BAUD_RATE   9600       default baud rate, used when baud_div == 0
//   DATA_BITS   8          data bits per frame, legal range 5..9
//   FIFO_DEPTH  16         FIFO entries; power of two, >= 2
//   DIV_W       16         width of the runtime baud divisor
// PORTS
//   clk          in   1                         clock, rising edge
//   rst_n        in   1                         asynchronous reset, active low
//   data         in   DATA_BITS                 word to transmit
//   data_valid   in   1                         data is valid
//   data_ready   out  1                         FIFO can accept a word (= !full)
//   baud_div     in   DIV_W                     clocks per bit; 0 selects CLK_FREQ/BAUD_RATE
//   stop2        in   1                         1 = two stop bits, 0 = one stop bit
//   parity_mode  in   2                         present only with UART_TX_PARITY_EN
//   tx           out  1                         serial line, idles high, registered
//   busy         out  1                         frame in progress or FIFO non-empty
//   fifo_count   out  $clog2(FIFO_DEPTH+1)      words currently held in the FIFO
// BEHAVIOUR
//   Reset (async, rst_n=0)
//     - tx=1, busy=0, fifo_count=0, data_ready=1.
//     - FIFO is flushed and FSM returns to IDLE immediately, including mid-frame.
//   Push / pop
//     - A push occurs when data_valid && data_ready.
//     - data_ready is derived from the registered count only.
//     - When full, a push is refused even if a pop occurs in the same cycle.
//     - Simultaneous push and pop when not full: count is unchanged.
//   FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE | START
//     - IDLE: when the FIFO is non-empty, pop the head word and latch data, baud_div
//       (0 -> CLK_FREQ/BAUD_RATE), stop2 and parity_mode; go to START.
//     - Each state holds tx for exactly div clocks, counted by a baud counter 0..div-1.
//     - DATA sends bit[i] for i = 0..DATA_BITS-1.
//     - STOP lasts 1 or 2 bit periods.
//     - At the end of STOP: a non-empty FIFO pops and goes straight to START
//       (no idle gap); otherwise go to IDLE.
//   Timing
//     - Handshake into an empty FIFO with FSM in IDLE: the pop happens on the next
//       clock, and tx falls on the clock after that (2-cycle latency).
//     - Frame length = (1 + DATA_BITS + P + S) * div clocks,
//       where P = parity bit (0/1) and S = stop bits (1/2).
//   Configuration timing
//     - Changes to baud_div, stop2 or parity_mode mid-frame take effect at the next frame.
//   Arithmetic
//     - Baud counter is DIV_W bits; div = 1 is legal (1 clock per bit).
//     - fifo_count saturates at FIFO_DEPTH by construction, never wraps.
//     - FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
// CONFIGURATION
//   UART_TX_PARITY_EN defined
//     - parity_mode port exists: 00 none, 01 even, 10 odd, 11 none (reserved).
//     - PARITY state sends ^data for even, ~^data for odd.
//   UART_TX_PARITY_EN undefined
//     - parity_mode port and PARITY state are absent; frames never carry parity.
// STRUCTURE
//   uart_pkg
//     - tx_state_e enum (IDLE, START, DATA, PARITY, STOP).
//     - parity_e enum (PAR_NONE, PAR_EVEN, PAR_ODD).
//   uart_fifo
//     - Synchronous FIFO sub-module parametrised by WIDTH and DEPTH.
//     - Outputs full, empty and count; reusable by the receive side.
//   uart_tx_fifo
//     - Holds the FSM, baud counter, bit index and shift register.
// TESTING
//   1. baud_div=4, push 0xA5 -> tx: 0x4, 1,0,1,0,0,1,0,1 (4 clk each), 1x4; 40 clk total.
//   2. FIFO_DEPTH=4, push 5 words with no drain -> data_ready=0 after 4; 5th accepted after first pop.
//   3. PARITY_EN, mode even, push 0x07 -> parity bit 1; mode odd -> parity bit 0.
//   4. stop2=1, baud_div=4, push 0x00,0xFF -> tx high 8 clk, then start bit of 0xFF, no gap.
//   5. rst_n low during DATA bit 3 -> tx=1, fifo_count=0, data_ready=1 in the same cycle.
//   6. CLK_FREQ=1000, BAUD_RATE=100, baud_div=0 -> each bit lasts exactly 10 clocks.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types for the UART transmit path (and later the receive side).
//   tx_state_e   : transmitter frame FSM states
//   parity_e     : decoded parity setting
//   decodeParity : maps the 2-bit parity_mode field onto parity_e; the
//                  reserved encoding 2'b11 is treated as "no parity"
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } parity_e;

    function automatic parity_e decodeParity(input logic [1:0] mode);
        parity_e result;
        case (mode)
            2'b01:   result = PAR_EVEN;
            2'b10:   result = PAR_ODD;
            default: result = PAR_NONE;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// ---------------------------------------------------------------------------
// uart_fifo
// Synchronous single-clock FIFO with occupancy count, shared by the UART
// transmit and receive paths. Read data is the head entry (show-ahead).
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset (flushes the FIFO)
//   push_i, wdata_i write request and data; ignored while full, even if a
//                   pop happens in the same cycle
//   pop_i, rdata_o  read request and head data; ignored while empty
//   full_o, empty_o occupancy flags derived from the registered count
//   count_o         number of entries held, 0..DEPTH
// ---------------------------------------------------------------------------
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           push_i,
    input  logic [WIDTH-1:0]               wdata_i,
    input  logic                           pop_i,
    output logic [WIDTH-1:0]               rdata_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             pushOk;
    logic             popOk;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rdPtr_q];
    assign pushOk  = push_i && !full_o;
    assign popOk   = pop_i && !empty_o;

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk_i) begin
        if (pushOk) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

    // A simultaneous accepted push and pop leaves the count unchanged.
    always_comb begin
        count_d = count_q;
        case ({pushOk, popOk})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers are exactly log2(DEPTH) bits wide, so they wrap on their own.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (pushOk) begin
                wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
            if (popOk) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Buffered UART transmitter. Words are queued through a valid/ready
// handshake and sent LSB first as start / data / [parity] / stop frames,
// back to back while the FIFO holds data.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   data_i             word to transmit (DATA_BITS wide)
//   data_valid_i       data_i is valid; pushed when data_ready_o is high
//   data_ready_o       FIFO not full (from the registered count)
//   baud_div_i         clocks per bit; 0 selects CLK_FREQ/BAUD_RATE
//   stop2_i            1 = two stop bits
//   parity_mode_i      00 none, 01 even, 10 odd, 11 none (parity builds only)
//   tx_o               registered serial line, idles high
//   busy_o             frame in progress or FIFO non-empty
//   fifo_count_o       words held in the FIFO
// Build option:
//   UART_TX_PARITY_EN  adds parity_mode_i and the PARITY state; without it
//                      frames never carry a parity bit.
// Configuration inputs are sampled when a word is popped, so changes made
// mid-frame apply from the next frame.
// ---------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [DATA_BITS-1:0]                data_i,
    input  logic                                data_valid_i,
    output logic                                data_ready_o,
    input  logic [DIV_W-1:0]                    baud_div_i,
    input  logic                                stop2_i,
`ifdef UART_TX_PARITY_EN
    input  logic [1:0]                          parity_mode_i,
`endif
    output logic                                tx_o,
    output logic                                busy_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count_o
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(CLK_FREQ / BAUD_RATE);

    tx_state_e              state_q, state_d;
    logic [DIV_W-1:0]       baudCnt_q, baudCnt_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [IDX_W-1:0]       bitIdx_q, bitIdx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   stop2_q, stop2_d;
    logic                   tx_q;
`ifdef UART_TX_PARITY_EN
    logic                   parEn_q, parEn_d;
    logic                   parBit_q, parBit_d;
    parity_e                parMode;
`endif

    logic                   fifoFull;
    logic                   fifoEmpty;
    logic [DATA_BITS-1:0]   fifoData;
    logic                   pushEn;
    logic                   popEn;
    logic                   loadFrame;
    logic                   bitEnd;
    logic                   txBit;

    assign data_ready_o = !fifoFull;
    assign pushEn       = data_valid_i && data_ready_o;
    assign bitEnd       = (baudCnt_q == div_q - DIV_W'(1));
    assign tx_o         = tx_q;
    assign busy_o       = (state_q != IDLE) || !fifoEmpty;

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (pushEn),
        .wdata_i (data_i),
        .pop_i   (popEn),
        .rdata_o (fifoData),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (fifo_count_o)
    );

    // Frame sequencing. bitIdx counts data bits in DATA and stop bits in
    // STOP. txBit is the level for the current state; it is registered into
    // tx_q, so the line trails the state by one clock throughout.
    always_comb begin
        state_d   = state_q;
        baudCnt_d = baudCnt_q;
        bitIdx_d  = bitIdx_q;
        shift_d   = shift_q;
        div_d     = div_q;
        stop2_d   = stop2_q;
`ifdef UART_TX_PARITY_EN
        parEn_d   = parEn_q;
        parBit_d  = parBit_q;
        parMode   = decodeParity(parity_mode_i);
`endif
        popEn     = 1'b0;
        loadFrame = 1'b0;
        txBit     = 1'b1;

        case (state_q)
            IDLE: begin
                if (!fifoEmpty) begin
                    loadFrame = 1'b1;
                end
            end
            START: begin
                txBit = 1'b0;
                if (bitEnd) begin
                    baudCnt_d = '0;
                    state_d   = DATA;
                end else begin
                    baudCnt_d = baudCnt_q + DIV_W'(1);
                end
            end
            DATA: begin
                txBit = shift_q[0];
                if (bitEnd) begin
                    baudCnt_d = '0;
                    shift_d   = shift_q >> 1;
                    if (bitIdx_q == IDX_W'(DATA_BITS - 1)) begin
                        bitIdx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d  = parEn_q ? PARITY : STOP;
`else
                        state_d  = STOP;
`endif
                    end else begin
                        bitIdx_d = bitIdx_q + IDX_W'(1);
                    end
                end else begin
                    baudCnt_d = baudCnt_q + DIV_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                txBit = parBit_q;
                if (bitEnd) begin
                    baudCnt_d = '0;
                    state_d   = STOP;
                end else begin
                    baudCnt_d = baudCnt_q + DIV_W'(1);
                end
            end
`endif
            STOP: begin
                txBit = 1'b1;
                if (bitEnd) begin
                    baudCnt_d = '0;
                    if (bitIdx_q == (stop2_q ? IDX_W'(1) : IDX_W'(0))) begin
                        bitIdx_d = '0;
                        if (!fifoEmpty) begin
                            loadFrame = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bitIdx_d = bitIdx_q + IDX_W'(1);
                    end
                end else begin
                    baudCnt_d = baudCnt_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Pop the head word and snapshot the line configuration for the
        // whole frame. Parity is computed here because the shift register
        // is consumed while the data bits go out.
        if (loadFrame) begin
            popEn     = 1'b1;
            shift_d   = fifoData;
            div_d     = (baud_div_i == '0) ? DEFAULT_DIV : baud_div_i;
            stop2_d   = stop2_i;
            baudCnt_d = '0;
            bitIdx_d  = '0;
            state_d   = START;
`ifdef UART_TX_PARITY_EN
            parEn_d   = (parMode != PAR_NONE);
            parBit_d  = (parMode == PAR_ODD) ? ~^fifoData : ^fifoData;
`endif
        end
    end

    // State and datapath registers; reset drops any frame in flight at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            baudCnt_q <= '0;
            bitIdx_q  <= '0;
            shift_q   <= '0;
            div_q     <= DEFAULT_DIV;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parEn_q   <= 1'b0;
            parBit_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            baudCnt_q <= baudCnt_d;
            bitIdx_q  <= bitIdx_d;
            shift_q   <= shift_d;
            div_q     <= div_d;
            stop2_q   <= stop2_d;
            tx_q      <= txBit;
`ifdef UART_TX_PARITY_EN
            parEn_q   <= parEn_d;
            parBit_q  <= parBit_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
// Self-checking bench for uart_tx_fifo. Every accepted word is turned into
// an expected frame on a timeline: it starts three sampled cycles after its
// handshake, but never before the previous frame has ended, and lasts
// (1 + DATA_BITS + P + S) * div clocks. A monitor samples the DUT on every
// falling edge and compares tx, fifo_count, data_ready and busy against
// that timeline. Parity is exercised when UART_TX_PARITY_EN is defined.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int CLK_FREQ    = 1000;
    localparam int BAUD_RATE   = 100;
    localparam int DATA_BITS   = 8;
    localparam int FIFO_DEPTH  = 4;
    localparam int DIV_W       = 16;
    localparam int CNT_W       = $clog2(FIFO_DEPTH+1);
    localparam int DEFAULT_DIV = CLK_FREQ / BAUD_RATE;

    typedef struct {
        int data;
        int div;
        int par;
        int accept;
        int start;
        int len;
        int stopAt;
    } frame_t;

    logic                 clk;
    logic                 rstN;
    logic [DATA_BITS-1:0] dataIn;
    logic                 dataValid;
    logic                 dataReady;
    logic [DIV_W-1:0]     baudDiv;
    logic                 stop2;
    logic [1:0]           parityMode;
    logic                 tx;
    logic                 busy;
    logic [CNT_W-1:0]     fifoCount;

    frame_t sb[$];
    frame_t cur;
    bit     curValid;
    int     cyc;
    int     lastEnd;
    int     lastStart;
    int     vectors;
    int     miscompares;
    int     cfgDiv;
    bit     cfgStop2;
    logic [1:0] cfgPar;

    uart_tx_fifo #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .DATA_BITS  (DATA_BITS),
        .FIFO_DEPTH (FIFO_DEPTH),
        .DIV_W      (DIV_W)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rstN),
        .data_i        (dataIn),
        .data_valid_i  (dataValid),
        .data_ready_o  (dataReady),
        .baud_div_i    (baudDiv),
        .stop2_i       (stop2),
`ifdef UART_TX_PARITY_EN
        .parity_mode_i (parityMode),
`endif
        .tx_o          (tx),
        .busy_o        (busy),
        .fifo_count_o  (fifoCount)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter advanced on the active edge; read at falling edges.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Safety net in case the run never reaches its summary.
    initial begin
        #600000;
        $display("[TB] FAIL watchdog: run did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int expectedBit(frame_t f, int j);
        int idx;
        int ones;
        idx  = (j - f.start) / f.div;
        ones = $countones(f.data) % 2;
        if (idx == 0) return 0;
        if (idx <= DATA_BITS) return (f.data >> (idx - 1)) & 1;
        if (f.par != 0 && idx == DATA_BITS + 1) return (f.par == 1) ? ones : 1 - ones;
        return 1;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    // Drive a new line configuration; it applies to frames popped afterwards.
    task automatic setConfig(input int div, input bit s2, input logic [1:0] par);
        cfgDiv     = div;
        cfgStop2   = s2;
        cfgPar     = par;
        baudDiv    = DIV_W'(div);
        stop2      = s2;
        parityMode = par;
    endtask

    // Offer one word (called just after a falling edge) and hold valid until
    // the DUT reports ready; the accepted word becomes an expected frame.
    task automatic applyStimulus(input int word);
        frame_t f;
        int waited;
        dataIn    = DATA_BITS'(word);
        dataValid = 1'b1;
        waited    = 0;
        while (!dataReady && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (!dataReady) begin
            checkOutput("push_timeout", 0, 1);
            dataValid = 1'b0;
            return;
        end
        f.data = word & ((1 << DATA_BITS) - 1);
        f.div  = (cfgDiv == 0) ? DEFAULT_DIV : cfgDiv;
`ifdef UART_TX_PARITY_EN
        f.par  = (cfgPar == 2'b01) ? 1 : (cfgPar == 2'b10) ? 2 : 0;
`else
        f.par  = 0;
`endif
        f.len    = (1 + DATA_BITS + ((f.par != 0) ? 1 : 0) + (cfgStop2 ? 2 : 1)) * f.div;
        f.accept = cyc;
        f.start  = (cyc + 3 > lastEnd + 1) ? cyc + 3 : lastEnd + 1;
        f.stopAt = f.start + f.len - 1;
        lastEnd   = f.stopAt;
        lastStart = f.start;
        sb.push_back(f);
        @(negedge clk);
        dataValid = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (cyc <= lastEnd + 2 && n < 20000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic waitCycle(input int target);
        int n;
        n = 0;
        while (cyc < target && n < 20000) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Monitor: retire the finished frame, pick up the frame that begins now,
    // and compare every observable output with the timeline.
    always @(negedge clk) begin
        int expTx;
        int expCount;
        bit expBusy;
        if (rstN) begin
            if (curValid && cyc > cur.stopAt) curValid = 1'b0;
            if (!curValid && sb.size() > 0 && sb[0].start == cyc) begin
                cur      = sb.pop_front();
                curValid = 1'b1;
            end
            expTx    = curValid ? expectedBit(cur, cyc) : 1;
            expCount = 0;
            foreach (sb[i]) begin
                if (sb[i].accept < cyc && sb[i].start > cyc + 1) expCount++;
            end
            expBusy = (expCount > 0) || (curValid && cyc <= cur.stopAt - 1) ||
                      (sb.size() > 0 && sb[0].start - 1 <= cyc);
            checkOutput("tx", int'(tx), expTx);
            checkOutput("fifo_count", int'(fifoCount), expCount);
            checkOutput("data_ready", int'(dataReady), (expCount < FIFO_DEPTH) ? 1 : 0);
            checkOutput("busy", int'(busy), int'(expBusy));
        end
    end

    // Directed scenarios first, then randomized segments with mid-frame
    // configuration changes.
    initial begin
        int target;
        int nWords;
        vectors     = 0;
        miscompares = 0;
        curValid    = 1'b0;
        lastEnd     = -100;
        lastStart   = -100;
        dataIn      = '0;
        dataValid   = 1'b0;
        rstN        = 1'b0;
        setConfig(4, 1'b0, 2'b00);

        repeat (2) @(negedge clk);
        checkOutput("reset_tx", int'(tx), 1);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_count", int'(fifoCount), 0);
        checkOutput("reset_ready", int'(dataReady), 1);
        #2 rstN = 1'b1;
        @(negedge clk);

        $display("[TB] single frame 0xA5 at div 4");
        applyStimulus(8'hA5);
        waitIdle();

        $display("[TB] default divisor");
        setConfig(0, 1'b0, 2'b00);
        applyStimulus(8'h3C);
        waitIdle();

        $display("[TB] two stop bits, back-to-back frames");
        setConfig(4, 1'b1, 2'b00);
        applyStimulus(8'h00);
        applyStimulus(8'hFF);
        waitIdle();

        $display("[TB] fill the FIFO");
        setConfig(8, 1'b0, 2'b00);
        for (int i = 0; i < 6; i++) applyStimulus(16 * i + 1);
        waitIdle();

`ifdef UART_TX_PARITY_EN
        $display("[TB] parity even then odd");
        setConfig(2, 1'b0, 2'b01);
        applyStimulus(8'h07);
        waitIdle();
        setConfig(2, 1'b0, 2'b10);
        applyStimulus(8'h07);
        waitIdle();
`endif

        $display("[TB] reset during data bit 3");
        setConfig(4, 1'b0, 2'b00);
        applyStimulus(8'h5A);
        target = lastStart + 4 * 4 + 1;
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        waitCycle(target);
        #2 rstN = 1'b0;
        #1;
        checkOutput("midreset_tx", int'(tx), 1);
        checkOutput("midreset_count", int'(fifoCount), 0);
        checkOutput("midreset_ready", int'(dataReady), 1);
        checkOutput("midreset_busy", int'(busy), 0);
        sb.delete();
        curValid  = 1'b0;
        lastEnd   = -100;
        lastStart = -100;
        repeat (2) @(negedge clk);
        #2 rstN = 1'b1;
        @(negedge clk);

        $display("[TB] randomized segments");
        for (int seg = 0; seg < 10; seg++) begin
            setConfig($urandom_range(0, 6), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            nWords = $urandom_range(1, 6);
            for (int w = 0; w < nWords; w++) begin
                applyStimulus($urandom_range(0, 255));
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            waitCycle(lastStart + 1);
            setConfig($urandom_range(1, 6), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            waitIdle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
